// File: rtl/lcd_init_sequencer.sv
// rtl/lcd_init_sequencer.sv - LCD power-on init script player with CPU pass-through to the SPI byte engine
module lcd_init_sequencer #(
    parameter int ROM_AW      = 8,
    parameter int DELAY_TICKS = 16000,
    parameter int DELAY_CW    = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              spi_valid,
    input  logic              spi_ready,
    output logic [7:0]        spi_byte,
    output logic              spi_dc,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [7:0]        cpu_byte,
    input  logic              cpu_dc,
    output logic              init_done,
    output logic              busy,
    output logic              rom_overrun
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_SEND   = 3'd3;
    localparam logic [2:0] ST_DELAY  = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;

    localparam logic [1:0] OP_CMD   = 2'b00;
    localparam logic [1:0] OP_DATA  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;

    localparam logic [DELAY_CW-1:0] TICK_LAST = DELAY_CW'(DELAY_TICKS - 1);
    localparam logic [ROM_AW-1:0]   ADDR_LAST = '1;

    logic [2:0]          state_q;
    logic [2:0]          state_d;
    logic [ROM_AW-1:0]   addr_d;
    logic [7:0]          byte_q;
    logic [7:0]          byte_d;
    logic                dc_q;
    logic                dc_d;
    logic                done_d;
    logic                busy_d;
    logic                overrun_d;
    logic [7:0]          unit_q;
    logic [7:0]          unit_d;
    logic [DELAY_CW-1:0] tick_q;
    logic [DELAY_CW-1:0] tick_d;
    logic                pend_q;
    logic                pend_d;
    logic                advance;

    // ROM entry fields; bits [13:8] carry no meaning for the sequencer
    logic [1:0] op;
    logic [7:0] arg;
    logic       unused_rom_bits;

    assign op              = rom_data[15:14];
    assign arg             = rom_data[7:0];
    assign unused_rom_bits = ^rom_data[13:8];

    logic in_run;
    logic run_stalled;
    logic restart;
    logic at_last;
    logic tick_wrap;

    // In RUN the CPU request is what the engine sees, so a stall is cpu_valid without ready
    assign in_run      = (state_q == ST_RUN);
    assign run_stalled = cpu_valid && !spi_ready;
    assign restart     = in_run && (start || pend_q) && !run_stalled;
    assign at_last     = (rom_addr == ADDR_LAST);
    assign tick_wrap   = (tick_q == TICK_LAST);

    // Engine-side mux: script bytes while initialising, CPU pass-through once in RUN
    assign spi_valid = in_run ? cpu_valid : (state_q == ST_SEND);
    assign spi_byte  = in_run ? cpu_byte  : byte_q;
    assign spi_dc    = in_run ? cpu_dc    : dc_q;
    assign cpu_ready = in_run && spi_ready;

    // Next-state and datapath decisions for the script walker
    always_comb begin
        state_d   = state_q;
        addr_d    = rom_addr;
        byte_d    = byte_q;
        dc_d      = dc_q;
        done_d    = init_done;
        busy_d    = busy;
        overrun_d = rom_overrun;
        unit_d    = unit_q;
        tick_d    = tick_q;
        pend_d    = pend_q;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                addr_d  = '0;
                busy_d  = 1'b1;
            end

            ST_FETCH: begin
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                case (op)
                    OP_CMD, OP_DATA: begin
                        byte_d  = arg;
                        dc_d    = op[0];
                        state_d = ST_SEND;
                    end
                    OP_DELAY: begin
                        if (arg != 8'd0) begin
                            unit_d  = arg;
                            tick_d  = '0;
                            state_d = ST_DELAY;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                endcase
            end

            ST_SEND: begin
                if (spi_ready) begin
                    advance = 1'b1;
                end
            end

            ST_DELAY: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    unit_d = unit_q - 8'd1;
                    if (unit_q == 8'd1) begin
                        advance = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (restart) begin
                    state_d   = ST_FETCH;
                    addr_d    = '0;
                    done_d    = 1'b0;
                    overrun_d = 1'b0;
                    busy_d    = 1'b1;
                    pend_d    = 1'b0;
                end else if (start && run_stalled) begin
                    pend_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Step to the next entry, or stop at the top of the ROM rather than wrapping
        if (advance) begin
            if (at_last) begin
                state_d   = ST_RUN;
                overrun_d = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end else begin
                addr_d  = rom_addr + 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    // State and output registers; reset drops everything, including an in-flight byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rom_addr    <= '0;
            byte_q      <= 8'd0;
            dc_q        <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b0;
            rom_overrun <= 1'b0;
            unit_q      <= 8'd0;
            tick_q      <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr    <= addr_d;
            byte_q      <= byte_d;
            dc_q        <= dc_d;
            init_done   <= done_d;
            busy        <= busy_d;
            rom_overrun <= overrun_d;
            unit_q      <= unit_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb/tb_lcd_init_sequencer.sv - scoreboard bench for lcd_init_sequencer
`timescale 1ns/1ps
module tb_lcd_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // DUT A: main script, 8-bit ROM address
    logic        rst_a, start_a, spi_ready_a, cpu_valid_a, cpu_dc_a;
    logic [7:0]  cpu_byte_a, rom_addr_a, spi_byte_a;
    logic [15:0] rom_data_a;
    logic        spi_valid_a, spi_dc_a, cpu_ready_a, init_done_a, busy_a, rom_overrun_a;
    logic [15:0] rom_a [0:255];

    // DUT B: overrun case, 3-bit ROM address with no END entry
    logic        rst_b, start_b, spi_ready_b, cpu_valid_b, cpu_dc_b;
    logic [7:0]  cpu_byte_b, spi_byte_b;
    logic [2:0]  rom_addr_b;
    logic [15:0] rom_data_b;
    logic        spi_valid_b, spi_dc_b, cpu_ready_b, init_done_b, busy_b, rom_overrun_b;
    logic [15:0] rom_b [0:7];

    lcd_init_sequencer #(.ROM_AW(8), .DELAY_TICKS(4), .DELAY_CW(3)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .spi_valid(spi_valid_a), .spi_ready(spi_ready_a), .spi_byte(spi_byte_a), .spi_dc(spi_dc_a),
        .cpu_valid(cpu_valid_a), .cpu_ready(cpu_ready_a), .cpu_byte(cpu_byte_a), .cpu_dc(cpu_dc_a),
        .init_done(init_done_a), .busy(busy_a), .rom_overrun(rom_overrun_a)
    );

    lcd_init_sequencer #(.ROM_AW(3), .DELAY_TICKS(4), .DELAY_CW(3)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .spi_valid(spi_valid_b), .spi_ready(spi_ready_b), .spi_byte(spi_byte_b), .spi_dc(spi_dc_b),
        .cpu_valid(cpu_valid_b), .cpu_ready(cpu_ready_b), .cpu_byte(cpu_byte_b), .cpu_dc(cpu_dc_b),
        .init_done(init_done_b), .busy(busy_b), .rom_overrun(rom_overrun_b)
    );

    // Synchronous ROMs: data valid one cycle after the address changes
    always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
    always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: expected {dc, byte} per engine handshake, plus handshake cycle stamps
    logic [8:0] exp_a [$];
    logic [8:0] exp_b [$];
    int         hs_a  [$];
    int         hs_b  [$];

    always @(negedge clk) begin
        if (spi_valid_a === 1'b1 && spi_ready_a === 1'b1) begin
            hs_a.push_back(cyc);
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected: got dc=%0b byte=0x%0h want no transfer", spi_dc_a, spi_byte_a);
            end else begin
                chk("a_byte", 32'({spi_dc_a, spi_byte_a}), 32'(exp_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (spi_valid_b === 1'b1 && spi_ready_b === 1'b1) begin
            hs_b.push_back(cyc);
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected: got dc=%0b byte=0x%0h want no transfer", spi_dc_b, spi_byte_b);
            end else begin
                chk("b_byte", 32'({spi_dc_b, spi_byte_b}), 32'(exp_b.pop_front()));
            end
        end
    end

    task automatic wait_hs_a(input int n, input int budget, input string name);
        int k = 0;
        while (hs_a.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (hs_a.size() < n) begin
            total++;
            bad++;
            $display("FAIL %s: timeout with %0d handshakes want %0d", name, hs_a.size(), n);
        end
    endtask

    task automatic wait_done_a(input int budget, input string name);
        int k = 0;
        while (init_done_a !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (init_done_a !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: timeout init_done=%0b want 1", name, init_done_a);
        end
    endtask

    logic b_done = 1'b0;

    // DUT B: ROM of CMD 0..7 without END must run off the end and park at address 7
    initial begin
        int k;
        rst_b = 1'b0; start_b = 1'b0; spi_ready_b = 1'b1;
        cpu_valid_b = 1'b0; cpu_byte_b = 8'h00; cpu_dc_b = 1'b0;
        for (int i = 0; i < 8; i++) rom_b[i] = 16'(i);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) exp_b.push_back(9'(i));
        @(posedge clk); #1;
        rst_b = 1'b1;
        k = 0;
        while (init_done_b !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("b_done", 32'(init_done_b), 32'd1);
        chk("b_overrun_addr", 32'({rom_overrun_b, busy_b, rom_addr_b}), 32'({1'b1, 1'b0, 3'd7}));
        chk("b_count", 32'(hs_b.size()), 32'd8);
        repeat (10) @(negedge clk);
        chk("b_addr_hold", 32'({rom_overrun_b, init_done_b, rom_addr_b}), 32'({1'b1, 1'b1, 3'd7}));
        chk("b_count_hold", 32'(hs_b.size()), 32'd8);
        b_done = 1'b1;
    end

    // DUT A: init script, backpressure, CPU hold-off, stalled restart, async reset
    initial begin
        int n;
        rst_a = 1'b0; start_a = 1'b0; spi_ready_a = 1'b0;
        cpu_valid_a = 1'b1; cpu_byte_a = 8'hA5; cpu_dc_a = 1'b1;
        for (int i = 0; i < 256; i++) rom_a[i] = 16'h0000;
        rom_a[0] = 16'h0011;
        rom_a[1] = 16'h8002;
        rom_a[2] = 16'h4055;
        rom_a[3] = 16'hC000;

        repeat (3) @(negedge clk);
        chk("rst_spi", 32'({spi_valid_a, spi_dc_a, spi_byte_a}), 32'd0);
        chk("rst_ctl", 32'({cpu_ready_a, init_done_a, busy_a, rom_overrun_a}), 32'd0);
        chk("rst_addr", 32'(rom_addr_a), 32'd0);

        exp_a.push_back({1'b0, 8'h11});
        exp_a.push_back({1'b1, 8'h55});
        exp_a.push_back({1'b1, 8'hA5});
        rst_a = 1'b1;

        n = 0;
        while (spi_valid_a !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'd3);

        for (int k = 0; k < 10; k++) begin
            chk("stall_hold", 32'({spi_valid_a, spi_dc_a, spi_byte_a, cpu_ready_a}), 32'({1'b1, 1'b0, 8'h11, 1'b0}));
            if (k < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        spi_ready_a = 1'b1;

        wait_hs_a(2, 40, "hs_init");
        if (hs_a.size() >= 2) chk("delay_gap", 32'(hs_a[1] - hs_a[0]), 32'd13);
        @(negedge clk);
        @(negedge clk);
        chk("done_before", 32'({init_done_a, busy_a, cpu_ready_a}), 32'({1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        chk("done_rise", 32'({init_done_a, busy_a, rom_overrun_a}), 32'({1'b1, 1'b0, 1'b0}));
        chk("end_addr", 32'(rom_addr_a), 32'd3);
        chk("cpu_pass", 32'({cpu_ready_a, spi_valid_a}), 32'({1'b1, 1'b1}));
        @(posedge clk); #1;
        cpu_valid_a = 1'b0;

        cpu_valid_a = 1'b1; cpu_byte_a = 8'h3C; cpu_dc_a = 1'b0;
        spi_ready_a = 1'b0; start_a = 1'b1;
        exp_a.push_back({1'b0, 8'h3C});
        exp_a.push_back({1'b0, 8'h11});
        exp_a.push_back({1'b1, 8'h55});
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("pend_hold", 32'({init_done_a, busy_a, spi_valid_a, cpu_ready_a, spi_byte_a}), 32'({4'b1010, 8'h3C}));
        end
        @(posedge clk); #1;
        spi_ready_a = 1'b1;
        @(negedge clk);
        chk("pend_handshake", 32'({init_done_a, cpu_ready_a}), 32'({1'b1, 1'b1}));
        @(posedge clk); #1;
        cpu_valid_a = 1'b0;
        @(negedge clk);
        chk("restart", 32'({init_done_a, busy_a, cpu_ready_a, rom_addr_a}), 32'({3'b010, 8'h00}));

        wait_hs_a(6, 60, "hs_replay");
        if (hs_a.size() >= 6) chk("replay_gap", 32'(hs_a[5] - hs_a[4]), 32'd13);
        wait_done_a(10, "done_replay");
        chk("replay_end", 32'({rom_overrun_a, rom_addr_a}), 32'({1'b0, 8'd3}));

        @(posedge clk); #1;
        start_a = 1'b1;
        exp_a.push_back({1'b0, 8'h11});
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_hs_a(7, 20, "hs_third");
        repeat (5) @(posedge clk);
        #2;
        chk("in_delay", 32'({busy_a, spi_valid_a, init_done_a}), 32'({1'b1, 1'b0, 1'b0}));
        rst_a = 1'b0;
        #1;
        chk("async_reset", 32'({spi_valid_a, spi_byte_a, spi_dc_a, cpu_ready_a, init_done_a, busy_a, rom_overrun_a, rom_addr_a}), 32'd0);
        exp_a.push_back({1'b0, 8'h11});
        exp_a.push_back({1'b1, 8'h55});
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
        n = 0;
        while (spi_valid_a !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("post_reset_addr", 32'({spi_valid_a, rom_addr_a}), 32'({1'b1, 8'h00}));
        wait_hs_a(9, 40, "hs_after_reset");
        if (hs_a.size() >= 9) chk("post_reset_gap", 32'(hs_a[8] - hs_a[7]), 32'd13);
        wait_done_a(10, "done_after_reset");
        repeat (5) @(negedge clk);
        chk("a_count", 32'(hs_a.size()), 32'd9);
        chk("a_queue_empty", 32'(exp_a.size()), 32'd0);

        n = 0;
        while (!b_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_finished", 32'(b_done), 32'd1);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
